// File: rtl/exec_sched.sv
// rtl/exec_sched.sv - fixed-latency execution tube scheduler with a single collision-free writeback port
module exec_sched #(
  parameter int REG_WIDTH          = 32,
  parameter int N_TUBES            = 3,
  parameter int TUBE_LAT [N_TUBES] = '{0, 4, 8},
  parameter int MAX_LAT            = 8,
  parameter int N_HARTS            = 4,
  parameter int OP_W               = 4,
  localparam int HART_W            = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [N_TUBES-1:0]                in_tube_sel,
  input  logic [OP_W-1:0]                   in_op,
  input  logic [REG_WIDTH-1:0]              in_data1,
  input  logic [REG_WIDTH-1:0]              in_data2,
  input  logic [HART_W-1:0]                 in_hart,
  input  logic [4:0]                        in_rd_addr,
  input  logic                              flush_valid,
  input  logic [HART_W-1:0]                 flush_hart,
  output logic [N_TUBES-1:0]                tube_in_valid,
  output logic [OP_W-1:0]                   tube_op,
  output logic [REG_WIDTH-1:0]              tube_data1,
  output logic [REG_WIDTH-1:0]              tube_data2,
  input  logic [N_TUBES-1:0]                tube_out_valid,
  input  logic [N_TUBES-1:0][REG_WIDTH-1:0] tube_out_data,
  output logic                              out_valid,
  output logic [HART_W-1:0]                 out_hart,
  output logic [4:0]                        out_rd_addr,
  output logic [REG_WIDTH-1:0]              out_data,
  output logic [N_HARTS-1:0]                hart_busy,
  output logic                              err
);

  localparam int TUBE_W = (N_TUBES > 1) ? $clog2(N_TUBES) : 1;
  localparam int LAT_W  = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
  localparam int CNT_W  = $clog2(MAX_LAT + 2);
  localparam int NSLOT  = MAX_LAT + 1;

  // Reservation slots: slot k holds the op that retires k cycles from now.
  logic [NSLOT-1:0]  occ_q, occ_d;
  logic [NSLOT-1:0]  kill_q, kill_d;
  logic [HART_W-1:0] hart_q [NSLOT];
  logic [HART_W-1:0] hart_d [NSLOT];
  logic [4:0]        rd_q   [NSLOT];
  logic [4:0]        rd_d   [NSLOT];
  logic [TUBE_W-1:0] tube_q [NSLOT];
  logic [TUBE_W-1:0] tube_d [NSLOT];
  logic [CNT_W-1:0]  cnt_q  [N_HARTS];
  logic [CNT_W-1:0]  cnt_d  [N_HARTS];
  logic              err_q, err_d;

  logic [TUBE_W-1:0]  sel_tube;
  logic [LAT_W-1:0]   sel_lat;
  logic [LAT_W-1:0]   ins_idx;
  logic               sel_onehot;
  logic               accept;
  logic               issue0;
  logic               issue_kill;
  logic               s0_occ;
  logic               s0_kill;
  logic [HART_W-1:0]  s0_hart;
  logic [4:0]         s0_rd;
  logic [TUBE_W-1:0]  s0_tube;
  logic [N_TUBES-1:0] tube_expect;
  logic [N_HARTS-1:0] hart_inc;
  logic [N_HARTS-1:0] hart_dec;

  // Decode the selected tube index and its fixed latency.
  always_comb begin
    sel_tube = '0;
    sel_lat  = '0;
    for (int i = 0; i < N_TUBES; i++) begin
      if (in_tube_sel[i]) begin
        sel_tube = TUBE_W'(i);
        sel_lat  = LAT_W'(TUBE_LAT[i]);
      end
    end
  end

  assign sel_onehot = $onehot(in_tube_sel);
  assign in_ready   = sel_onehot & ~occ_q[sel_lat];
  assign accept     = in_valid & in_ready;
  assign issue0     = accept & (sel_lat == '0);
  assign issue_kill = flush_valid & (flush_hart == in_hart);
  assign ins_idx    = sel_lat - LAT_W'(1);

  assign tube_in_valid = {N_TUBES{accept & rst_n}} & in_tube_sel;
  assign tube_op       = in_op;
  assign tube_data1    = in_data1;
  assign tube_data2    = in_data2;

  // Effective slot 0: the stored entry, or a zero-latency issue retiring this same cycle.
  always_comb begin
    s0_occ  = occ_q[0] | issue0;
    s0_hart = hart_q[0];
    s0_rd   = rd_q[0];
    s0_tube = tube_q[0];
    s0_kill = kill_q[0] | (flush_valid & occ_q[0] & (flush_hart == hart_q[0]));
    if (issue0) begin
      s0_hart = in_hart;
      s0_rd   = in_rd_addr;
      s0_tube = sel_tube;
      s0_kill = issue_kill;
    end
  end

  assign out_valid   = rst_n & s0_occ & ~s0_kill;
  assign out_hart    = s0_hart;
  assign out_rd_addr = s0_rd;
  assign out_data    = out_valid ? tube_out_data[s0_tube] : '0;

  // Tube that must deliver a result this cycle; any other valid pattern is a protocol error.
  always_comb begin
    tube_expect = '0;
    if (s0_occ) tube_expect[s0_tube] = 1'b1;
  end

  assign err_d = err_q | (|(tube_out_valid ^ tube_expect));
  assign err   = err_q;

  // Shift reservations down one slot, apply flush kills, insert the accepted issue.
  always_comb begin
    for (int k = 0; k < NSLOT; k++) begin
      occ_d[k]  = 1'b0;
      kill_d[k] = 1'b0;
      hart_d[k] = '0;
      rd_d[k]   = '0;
      tube_d[k] = '0;
    end
    for (int k = 0; k < MAX_LAT; k++) begin
      occ_d[k]  = occ_q[k+1];
      kill_d[k] = kill_q[k+1] | (flush_valid & occ_q[k+1] & (flush_hart == hart_q[k+1]));
      hart_d[k] = hart_q[k+1];
      rd_d[k]   = rd_q[k+1];
      tube_d[k] = tube_q[k+1];
    end
    if (accept && (sel_lat != '0)) begin
      occ_d[ins_idx]  = 1'b1;
      kill_d[ins_idx] = issue_kill;
      hart_d[ins_idx] = in_hart;
      rd_d[ins_idx]   = in_rd_addr;
      tube_d[ins_idx] = sel_tube;
    end
  end

  // Per-hart in-flight counters; a zero-latency op counts up and down in the same cycle.
  always_comb begin
    hart_busy = '0;
    hart_inc  = '0;
    hart_dec  = '0;
    for (int h = 0; h < N_HARTS; h++) begin
      hart_inc[h] = accept & (in_hart == HART_W'(h));
      hart_dec[h] = s0_occ & (s0_hart == HART_W'(h));
      cnt_d[h]    = cnt_q[h];
      if (hart_inc[h] && !hart_dec[h]) cnt_d[h] = cnt_q[h] + CNT_W'(1);
      else if (!hart_inc[h] && hart_dec[h]) cnt_d[h] = cnt_q[h] - CNT_W'(1);
      hart_busy[h] = rst_n & ((cnt_q[h] != '0) | (issue0 & (in_hart == HART_W'(h))));
    end
  end

  // State register with asynchronous clear of all in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= '0;
      kill_q <= '0;
      err_q  <= 1'b0;
      for (int k = 0; k < NSLOT; k++) begin
        hart_q[k] <= '0;
        rd_q[k]   <= '0;
        tube_q[k] <= '0;
      end
      for (int h = 0; h < N_HARTS; h++) cnt_q[h] <= '0;
    end else begin
      occ_q  <= occ_d;
      kill_q <= kill_d;
      err_q  <= err_d;
      hart_q <= hart_d;
      rd_q   <= rd_d;
      tube_q <= tube_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_exec_sched.sv
// tb/tb_exec_sched.sv - self-checking bench for exec_sched
module tb_exec_sched;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_tube_sel;
  logic [3:0]        in_op;
  logic [31:0]       in_data1, in_data2;
  logic [1:0]        in_hart;
  logic [4:0]        in_rd_addr;
  logic              flush_valid;
  logic [1:0]        flush_hart;
  logic [2:0]        tube_in_valid;
  logic [3:0]        tube_op;
  logic [31:0]       tube_data1, tube_data2;
  logic [2:0]        tube_out_valid;
  logic [2:0][31:0]  tube_out_data;
  logic              out_valid;
  logic [1:0]        out_hart;
  logic [4:0]        out_rd_addr;
  logic [31:0]       out_data;
  logic [3:0]        hart_busy;
  logic              err;

  exec_sched dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_tube_sel(in_tube_sel), .in_op(in_op),
    .in_data1(in_data1), .in_data2(in_data2), .in_hart(in_hart), .in_rd_addr(in_rd_addr),
    .flush_valid(flush_valid), .flush_hart(flush_hart),
    .tube_in_valid(tube_in_valid), .tube_op(tube_op), .tube_data1(tube_data1), .tube_data2(tube_data2),
    .tube_out_valid(tube_out_valid), .tube_out_data(tube_out_data),
    .out_valid(out_valid), .out_hart(out_hart), .out_rd_addr(out_rd_addr), .out_data(out_data),
    .hart_busy(hart_busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ret;
    int hart;
    int rd;
    int tube;
    bit killed;
  } op_t;

  typedef struct {
    bit         v;
    logic [2:0] sel;
    int         hart;
    int         rd;
    bit         rdy;
    bit         ov;
    int         ord;
  } vec_t;

  int   tl [3] = '{0, 4, 8};
  op_t  q[$];
  int   cyc;
  bit   err_m;
  logic [2:0] inject;
  int   n_checks;
  int   n_err;

  bit         obs_rdy;
  bit         obs_ov;
  int         obs_rd;
  logic [3:0] obs_busy;
  bit         obs_err;

  vec_t tbl [12];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One clock cycle: drive inputs, predict from the in-flight op list, compare, advance.
  task automatic run_cycle(input bit v, input logic [2:0] sel, input int hart, input int rd,
                           input bit fv, input int fh);
    int lat;
    int tube;
    bit oh;
    bit exp_rdy;
    bit acc;
    bit exp_ov;
    int exp_hart;
    int exp_rd;
    int ret_tube;
    logic [3:0]  exp_busy;
    logic [2:0]  exp_tov;
    logic [2:0]  exp_tiv;
    logic [31:0] exp_data;
    op_t nop;
    lat = 0;
    tube = 0;
    oh = $onehot(sel);
    for (int i = 0; i < 3; i++) if (sel[i]) begin lat = tl[i]; tube = i; end
    exp_rdy = oh;
    if (oh) foreach (q[j]) if (q[j].ret == cyc + lat) exp_rdy = 1'b0;
    acc = v && exp_rdy;
    exp_busy = '0;
    foreach (q[j]) exp_busy[q[j].hart] = 1'b1;
    if (fv) foreach (q[j]) if (q[j].hart == fh) q[j].killed = 1'b1;
    if (acc) begin
      nop.ret = cyc + lat; nop.hart = hart; nop.rd = rd; nop.tube = tube;
      nop.killed = fv && (fh == hart);
      q.push_back(nop);
      if (lat == 0) exp_busy[hart] = 1'b1;
    end
    exp_tiv = acc ? sel : 3'b000;
    exp_tov = '0; exp_ov = 1'b0; exp_hart = 0; exp_rd = 0; ret_tube = 0;
    foreach (q[j]) if (q[j].ret == cyc) begin
      exp_tov[q[j].tube] = 1'b1;
      exp_ov   = !q[j].killed;
      exp_hart = q[j].hart;
      exp_rd   = q[j].rd;
      ret_tube = q[j].tube;
    end
    in_valid    = v;
    in_tube_sel = sel;
    in_hart     = 2'(hart);
    in_rd_addr  = 5'(rd);
    in_op       = 4'($urandom_range(0, 15));
    in_data1    = $urandom;
    in_data2    = $urandom;
    flush_valid = fv;
    flush_hart  = 2'(fh);
    for (int i = 0; i < 3; i++) tube_out_data[i] = $urandom;
    tube_out_valid = exp_tov ^ inject;
    @(negedge clk);
    exp_data = exp_ov ? tube_out_data[ret_tube] : 32'h0;
    chk("in_ready", in_ready, exp_rdy);
    chk("tube_in_valid", tube_in_valid, exp_tiv);
    chk("tube_data1", tube_data1, in_data1);
    chk("out_valid", out_valid, exp_ov);
    chk("out_data", out_data, exp_data);
    if (exp_ov) begin
      chk("out_rd_addr", out_rd_addr, exp_rd);
      chk("out_hart", out_hart, exp_hart);
    end
    chk("hart_busy", hart_busy, exp_busy);
    chk("err", err, err_m);
    obs_rdy = in_ready; obs_ov = out_valid; obs_rd = int'(out_rd_addr);
    obs_busy = hart_busy; obs_err = err;
    @(posedge clk);
    if (inject != 3'b000) err_m = 1'b1;
    for (int j = q.size() - 1; j >= 0; j--) if (q[j].ret == cyc) q.delete(j);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 3'b000, 0, 0, 1'b0, 0);
  endtask

  initial begin
    n_checks = 0; n_err = 0; cyc = 0; err_m = 1'b0; inject = 3'b000;
    rst_n = 1'b0; in_valid = 1'b0; in_tube_sel = '0; in_op = '0; in_data1 = '0; in_data2 = '0;
    in_hart = '0; in_rd_addr = '0; flush_valid = 1'b0; flush_hart = '0;
    tube_out_valid = '0; tube_out_data = '0;

    tbl[0]  = '{1'b1, 3'b010, 0, 5,  1'b1, 1'b0, 0};
    tbl[1]  = '{1'b1, 3'b100, 1, 7,  1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 3'b010, 0, 0,  1'b1, 1'b0, 0};
    tbl[3]  = '{1'b1, 3'b001, 2, 9,  1'b1, 1'b1, 9};
    tbl[4]  = '{1'b1, 3'b001, 2, 10, 1'b0, 1'b1, 5};
    tbl[5]  = '{1'b1, 3'b010, 3, 11, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1, 3'b010, 3, 11, 1'b1, 1'b0, 0};
    tbl[7]  = '{1'b1, 3'b000, 0, 0,  1'b0, 1'b0, 0};
    tbl[8]  = '{1'b1, 3'b011, 0, 0,  1'b0, 1'b0, 0};
    tbl[9]  = '{1'b0, 3'b100, 0, 0,  1'b1, 1'b1, 7};
    tbl[10] = '{1'b0, 3'b001, 0, 0,  1'b0, 1'b1, 11};
    tbl[11] = '{1'b0, 3'b001, 0, 0,  1'b1, 1'b0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_err", err, 1'b0);
    rst_n = 1'b1;

    // Directed vectors: latency collisions, zero-latency same-cycle retire, bad selects.
    for (int i = 0; i < 12; i++) begin
      run_cycle(tbl[i].v, tbl[i].sel, tbl[i].hart, tbl[i].rd, 1'b0, 0);
      chk("tbl_ready", obs_rdy, tbl[i].rdy);
      chk("tbl_out_valid", obs_ov, tbl[i].ov);
      if (tbl[i].ov) chk("tbl_out_rd", obs_rd, tbl[i].ord);
    end
    idle(10);

    // Flush of hart 1 with ops on tube2 and tube1, plus a killed zero-latency issue.
    run_cycle(1'b1, 3'b100, 1, 1, 1'b0, 0);
    run_cycle(1'b1, 3'b010, 1, 2, 1'b0, 0);
    run_cycle(1'b1, 3'b010, 0, 3, 1'b1, 1);
    run_cycle(1'b1, 3'b001, 1, 4, 1'b1, 1);
    chk("flush_l0_ready", obs_rdy, 1'b1);
    chk("flush_l0_killed", obs_ov, 1'b0);
    run_cycle(1'b0, 3'b000, 0, 0, 1'b0, 0);
    run_cycle(1'b0, 3'b000, 0, 0, 1'b0, 0);
    chk("flush_tube1_killed", obs_ov, 1'b0);
    run_cycle(1'b0, 3'b000, 0, 0, 1'b0, 0);
    chk("flush_hart0_kept", obs_ov, 1'b1);
    chk("flush_hart0_rd", obs_rd, 3);
    chk("flush_hart0_busy", obs_busy[0], 1'b1);
    run_cycle(1'b0, 3'b000, 0, 0, 1'b0, 0);
    chk("flush_hart0_idle", obs_busy[0], 1'b0);
    run_cycle(1'b0, 3'b000, 0, 0, 1'b0, 0);
    chk("flush_tube2_killed", obs_ov, 1'b0);
    chk("flush_busy_held", obs_busy[1], 1'b1);
    run_cycle(1'b0, 3'b000, 0, 0, 1'b0, 0);
    chk("flush_busy_drop", obs_busy[1], 1'b0);
    idle(2);

    // Randomized traffic against the op-list model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] s;
      if ($urandom_range(0, 9) < 8) s = 3'b001 << $urandom_range(0, 2);
      else s = 3'($urandom_range(0, 7));
      run_cycle(1'($urandom_range(0, 3) != 0), s, $urandom_range(0, 3), $urandom_range(0, 31),
                1'($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end
    idle(10);

    // Unexpected tube result with empty slot 0 makes err sticky.
    inject = 3'b010;
    run_cycle(1'b0, 3'b000, 0, 0, 1'b0, 0);
    inject = 3'b000;
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, 3'b000, 0, 0, 1'b0, 0);
      chk("err_sticky", obs_err, 1'b1);
    end

    // Reset with three ops in flight and a zero-latency issue being presented.
    run_cycle(1'b1, 3'b100, 0, 1, 1'b0, 0);
    run_cycle(1'b1, 3'b010, 1, 2, 1'b0, 0);
    run_cycle(1'b1, 3'b100, 2, 3, 1'b0, 0);
    in_valid = 1'b1; in_tube_sel = 3'b001; in_hart = 2'd3; flush_valid = 1'b0; tube_out_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_hart_busy", hart_busy, 4'b0000);
    chk("rst_tube_in_valid", tube_in_valid, 3'b000);
    chk("rst_err", err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    q.delete();
    err_m = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [2:0] s;
      s = 3'b001 << i;
      run_cycle(1'b0, s, 0, 0, 1'b0, 0);
      chk("post_rst_ready", obs_rdy, 1'b1);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
